// File: rtl/scrambler_frame_ctrl.sv
// Frame sequencer for the 802.11a DATA-field scrambler (x^7+x^4+1): SERVICE, PSDU,
// zeroed tail and scrambled pad, serialised LSB first with valid/ready on both sides.
module scrambler_frame_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  seed,
    input  logic [11:0] psdu_len,
    input  logic [8:0]  n_dbps,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        bit_out,
    output logic        bit_valid,
    input  logic        bit_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVICE,
        ST_DATA,
        ST_TAIL,
        ST_PAD
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  lfsr_q, lfsr_d;          // bit 6 is the x^7 stage
    logic [8:0]  n_dbps_q, n_dbps_d;
    logic [8:0]  sym_cnt_q, sym_cnt_d;
    logic [3:0]  phase_cnt_q, phase_cnt_d;
    logic [11:0] bytes_rem_q, bytes_rem_d;
    logic [7:0]  buf_q, buf_d;
    logic        buf_full_q, buf_full_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        bit_out_q, bit_out_d;
    logic        bit_valid_q, bit_valid_d;
    logic        byte_ready_q, byte_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic seq;
    logic seq_d;
    logic bit_xfer;
    logic byte_xfer;
    logic sym_wrap;

    assign seq       = lfsr_q[6] ^ lfsr_q[3];
    assign bit_xfer  = bit_valid_q & bit_ready;
    assign byte_xfer = byte_ready_q & byte_valid;
    assign sym_wrap  = (sym_cnt_q == n_dbps_q - 9'd1);

    always_comb begin
        // NOTE: every next-state signal defaults to its current value so no latch is inferred.
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        n_dbps_d    = n_dbps_q;
        sym_cnt_d   = sym_cnt_q;
        phase_cnt_d = phase_cnt_q;
        bytes_rem_d = bytes_rem_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        bit_idx_d   = bit_idx_q;
        done_d      = 1'b0;

        if (bit_xfer) begin
            lfsr_d    = {lfsr_q[5:0], seq};
            sym_cnt_d = sym_wrap ? 9'd0 : sym_cnt_q + 9'd1;
        end

        // A byte is only accepted into an empty buffer, so this never collides
        // with the buffer draining its last bit below.
        if (byte_xfer) begin
            buf_d       = byte_data;
            buf_full_d  = 1'b1;
            bit_idx_d   = 3'd0;
            bytes_rem_d = bytes_rem_q - 12'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SERVICE;
                    lfsr_d      = (seed == 7'd0) ? 7'h7F : seed;
                    n_dbps_d    = n_dbps;
                    bytes_rem_d = psdu_len;
                    sym_cnt_d   = 9'd0;
                    phase_cnt_d = 4'd0;
                    buf_full_d  = 1'b0;
                    bit_idx_d   = 3'd0;
                end
            end
            ST_SERVICE: begin
                if (bit_xfer) begin
                    phase_cnt_d = phase_cnt_q + 4'd1;
                    if (phase_cnt_q == 4'd15) begin
                        phase_cnt_d = 4'd0;
                        // Buffer can only be empty with nothing left when the PSDU is empty.
                        state_d = (bytes_rem_q == 12'd0 && !buf_full_q) ? ST_TAIL : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bit_xfer) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        buf_full_d = 1'b0;
                        if (bytes_rem_q == 12'd0) begin
                            state_d = ST_TAIL;
                        end
                    end
                end
            end
            ST_TAIL: begin
                if (bit_xfer) begin
                    phase_cnt_d = phase_cnt_q + 4'd1;
                    if (phase_cnt_q == 4'd5) begin
                        phase_cnt_d = 4'd0;
                        if (sym_wrap) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                if (bit_xfer && sym_wrap) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from next state and registered, so no input reaches an output
    // in the same cycle and bit_out holds naturally while the LFSR is frozen.
    always_comb begin
        seq_d        = lfsr_d[6] ^ lfsr_d[3];
        bit_valid_d  = 1'b0;
        bit_out_d    = 1'b0;
        case (state_d)
            ST_SERVICE: begin
                bit_valid_d = 1'b1;
                bit_out_d   = seq_d;
            end
            ST_DATA: begin
                bit_valid_d = buf_full_d;
                bit_out_d   = buf_full_d & (seq_d ^ buf_d[bit_idx_d]);
            end
            ST_TAIL: begin
                bit_valid_d = 1'b1;
                bit_out_d   = 1'b0;
            end
            ST_PAD: begin
                bit_valid_d = 1'b1;
                bit_out_d   = seq_d;
            end
            default: begin
                bit_valid_d = 1'b0;
                bit_out_d   = 1'b0;
            end
        endcase
        byte_ready_d = !buf_full_d && (bytes_rem_d != 12'd0) &&
                       (state_d == ST_SERVICE || state_d == ST_DATA);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= 7'h7F;
            n_dbps_q     <= 9'd0;
            sym_cnt_q    <= 9'd0;
            phase_cnt_q  <= 4'd0;
            bytes_rem_q  <= 12'd0;
            buf_q        <= 8'd0;
            buf_full_q   <= 1'b0;
            bit_idx_q    <= 3'd0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            n_dbps_q     <= n_dbps_d;
            sym_cnt_q    <= sym_cnt_d;
            phase_cnt_q  <= phase_cnt_d;
            bytes_rem_q  <= bytes_rem_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            bit_idx_q    <= bit_idx_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign byte_ready = byte_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
